// File: rtl/common_types_pkg.sv
`default_nettype none
// ============================================================================
// common_types_pkg : shared AHB encodings, manager FSM states, phase record
// Rev 1.0
// ============================================================================
package common_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_PIPE = 3'd2,
        ST_DATA = 3'd3,
        ST_ERR2 = 3'd4
    } state_e;

    typedef struct packed {
        logic       valid;
        word_t      addr;
        logic       write;
        logic [1:0] size;
        word_t      wdata;
    } phase_t;

    localparam logic [2:0] HBURST_SINGLE   = 3'b000;
    localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

endpackage
`default_nettype wire

// File: rtl/ahb_phase_reg.sv
`default_nettype none
// ============================================================================
// ahb_phase_reg : one bus-phase register set (addr/write/size/wdata + valid)
// Rev 1.0
// ============================================================================
module ahb_phase_reg
    import common_types_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load_i,
    input  logic   clr_i,
    input  phase_t d_i,
    output phase_t q_o
);

    phase_t phase_q;

    // Clearing only drops valid so the bus keeps its last values stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
        end else if (load_i) begin
            phase_q <= d_i;
        end else if (clr_i) begin
            phase_q.valid <= 1'b0;
        end
    end

    assign q_o = phase_q;

endmodule
`default_nettype wire

// File: rtl/ahb_manager.sv
`default_nettype none
// ============================================================================
// ahb_manager : pipelined single-transfer AHB manager with in-order responses
// Rev 1.0
// ============================================================================
module ahb_manager
    import common_types_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  word_t       req_addr,
    input  word_t       req_wdata,
    input  logic [1:0]  req_size,
    output logic        rsp_valid,
    output word_t       rsp_rdata,
    output logic        rsp_err,
    output word_t       haddr,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [1:0]  htrans,
    output logic [2:0]  hburst,
    output logic [3:0]  hprot,
    output logic        hmastlock,
    output word_t       hwdata,
    input  logic        hready,
    input  word_t       hrdata,
    input  logic        hresp
);

    state_e state_q, state_d;
    phase_t a_q, d_q, req_phase;
    logic   a_load, a_clr, d_load, d_clr;
    logic   rsp_fire, rsp_err_d;
    logic   cancel_q, cancel_d;
    logic   rsp_valid_q, rsp_err_q;
    word_t  rsp_rdata_q;
    logic   accept, err_wait, unused_dphase;

    assign req_phase = '{valid: 1'b1, addr: req_addr, write: req_write,
                         size: req_size, wdata: req_wdata};

    ahb_phase_reg u_aphase (
        .clk    (clk),
        .rst    (rst),
        .load_i (a_load),
        .clr_i  (a_clr),
        .d_i    (req_phase),
        .q_o    (a_q)
    );

    ahb_phase_reg u_dphase (
        .clk    (clk),
        .rst    (rst),
        .load_i (d_load),
        .clr_i  (d_clr),
        .d_i    (a_q),
        .q_o    (d_q)
    );

    assign err_wait = (hresp == HRESP_ERROR) && !hready;
    assign accept   = req_valid && req_ready;

    always_comb begin
        req_ready = 1'b0;
        case (state_q)
            ST_IDLE:                   req_ready = 1'b1;
            ST_ADDR, ST_PIPE, ST_DATA: req_ready = hready && (hresp == HRESP_OKAY);
            default:                   req_ready = 1'b0;
        endcase
        if (rst) begin
            req_ready = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_load    = 1'b0;
        a_clr     = 1'b0;
        d_load    = 1'b0;
        d_clr     = 1'b0;
        rsp_fire  = 1'b0;
        rsp_err_d = 1'b0;
        cancel_d  = cancel_q;
        case (state_q)
            ST_IDLE: begin
                // Report the address phase cancelled by the previous error.
                if (cancel_q) begin
                    rsp_fire  = 1'b1;
                    rsp_err_d = 1'b1;
                    cancel_d  = 1'b0;
                end
                if (accept) begin
                    a_load  = 1'b1;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (hready) begin
                    d_load  = 1'b1;
                    a_load  = accept;
                    a_clr   = !accept;
                    state_d = accept ? ST_PIPE : ST_DATA;
                end
            end
            ST_PIPE: begin
                if (err_wait) begin
                    a_clr    = 1'b1;
                    cancel_d = 1'b1;
                    state_d  = ST_ERR2;
                end else if (hready) begin
                    rsp_fire  = 1'b1;
                    rsp_err_d = hresp;
                    d_load    = 1'b1;
                    a_load    = accept;
                    a_clr     = !accept;
                    state_d   = accept ? ST_PIPE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (err_wait) begin
                    state_d = ST_ERR2;
                end else if (hready) begin
                    rsp_fire  = 1'b1;
                    rsp_err_d = hresp;
                    d_clr     = 1'b1;
                    a_load    = accept;
                    state_d   = accept ? ST_ADDR : ST_IDLE;
                end
            end
            ST_ERR2: begin
                if (hready) begin
                    rsp_fire  = 1'b1;
                    rsp_err_d = 1'b1;
                    d_clr     = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cancel_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cancel_q    <= cancel_d;
            rsp_valid_q <= rsp_fire;
            rsp_err_q   <= rsp_fire && rsp_err_d;
            rsp_rdata_q <= (rsp_fire && !rsp_err_d && !d_q.write) ? hrdata : '0;
        end
    end

    // The data-phase copy of address and size is never driven onto the bus.
    assign unused_dphase = ^{d_q.addr, d_q.size, d_q.valid};

    // An ERROR wait cycle withdraws any overlapping address phase at once.
    assign htrans    = (a_q.valid && !(state_q == ST_PIPE && err_wait)) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr     = a_q.addr;
    assign hwrite    = a_q.write;
    assign hsize     = {1'b0, a_q.size};
    assign hwdata    = d_q.wdata;
    assign hburst    = HBURST_SINGLE;
    assign hprot     = HPROT_DATA_PRIV;
    assign hmastlock = 1'b0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_manager.sv
`default_nettype none
// ============================================================================
// tb_ahb_manager : directed-vector bench for ahb_manager
// Rev 1.0
// ============================================================================
module tb_ahb_manager;
    import common_types_pkg::*;

    logic        clk, rst;
    logic        req_valid, req_ready, req_write;
    word_t       req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_err;
    word_t       rsp_rdata;
    word_t       haddr, hwdata, hrdata;
    logic        hwrite, hmastlock, hready, hresp;
    logic [2:0]  hsize, hburst;
    logic [1:0]  htrans;
    logic [3:0]  hprot;

    int n_vec = 0;
    int n_err = 0;

    ahb_manager u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_size  (req_size),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .haddr     (haddr),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .htrans    (htrans),
        .hburst    (hburst),
        .hprot     (hprot),
        .hmastlock (hmastlock),
        .hwdata    (hwdata),
        .hready    (hready),
        .hrdata    (hrdata),
        .hresp     (hresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input logic v, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [1:0] s);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_size  = s;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = '0;
        drive_req(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);

        // Reset values
        @(negedge clk);
        chk("rst_htrans",    32'(htrans),    32'h0);
        chk("rst_haddr",     haddr,          32'h0);
        chk("rst_hwrite",    32'(hwrite),    32'h0);
        chk("rst_hsize",     32'(hsize),     32'h0);
        chk("rst_hwdata",    hwdata,         32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata,      32'h0);
        chk("rst_rsp_err",   32'(rsp_err),   32'h0);
        chk("rst_ready",     32'(req_ready), 32'h0);
        chk("hburst",        32'(hburst),    32'h0);
        chk("hprot",         32'(hprot),     32'h3);
        chk("hmastlock",     32'(hmastlock), 32'h0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rel_ready", 32'(req_ready), 32'h1);

        // Single zero-wait read
        next_cycle();
        drive_req(1'b1, 1'b0, 32'h100, 32'h0, 2'd2);
        @(negedge clk);
        chk("rd_ready",   32'(req_ready), 32'h1);
        chk("rd_t0_trans", 32'(htrans),   32'h0);
        next_cycle();
        drive_req(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        @(negedge clk);
        chk("rd_htrans", 32'(htrans), 32'h2);
        chk("rd_haddr",  haddr,       32'h100);
        chk("rd_hwrite", 32'(hwrite), 32'h0);
        chk("rd_hsize",  32'(hsize),  32'h2);
        next_cycle();
        hrdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("rd_dph_trans", 32'(htrans),    32'h0);
        chk("rd_dph_rsp",   32'(rsp_valid), 32'h0);
        next_cycle();
        hrdata = 32'h0;
        @(negedge clk);
        chk("rd_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("rd_rsp_rdata", rsp_rdata,      32'hDEADBEEF);
        chk("rd_rsp_err",   32'(rsp_err),   32'h0);

        // Four back-to-back word writes
        for (int k = 0; k < 7; k++) begin
            next_cycle();
            if (k < 4) drive_req(1'b1, 1'b1, 32'(4 * k), 32'(k + 1), 2'd2);
            else       drive_req(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
            @(negedge clk);
            if (k < 4) chk("b2b_ready", 32'(req_ready), 32'h1);
            chk("b2b_htrans", 32'(htrans), (k >= 1 && k <= 4) ? 32'h2 : 32'h0);
            if (k >= 1 && k <= 4) chk("b2b_haddr", haddr, 32'(4 * (k - 1)));
            if (k >= 2 && k <= 5) chk("b2b_hwdata", hwdata, 32'(k - 1));
            chk("b2b_rsp_valid", 32'(rsp_valid), (k >= 3 && k <= 6) ? 32'h1 : 32'h0);
            if (k >= 3 && k <= 6) chk("b2b_rsp_rdata", rsp_rdata, 32'h0);
        end

        // Write stalled 3 cycles with a pipelined read behind it
        next_cycle();
        drive_req(1'b1, 1'b1, 32'h200, 32'hA5A50001, 2'd2);
        @(negedge clk);
        chk("st_ready0", 32'(req_ready), 32'h1);
        next_cycle();
        drive_req(1'b1, 1'b0, 32'h204, 32'h0, 2'd2);
        @(negedge clk);
        chk("st_ready1", 32'(req_ready), 32'h1);
        chk("st_haddr0", haddr,          32'h200);
        chk("st_hwrite", 32'(hwrite),    32'h1);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            drive_req(1'b1, 1'b0, 32'h208, 32'h0, 2'd2);
            hready = 1'b0;
            @(negedge clk);
            chk("st_hwdata", hwdata,          32'hA5A50001);
            chk("st_haddr",  haddr,           32'h204);
            chk("st_htrans", 32'(htrans),     32'h2);
            chk("st_ready",  32'(req_ready),  32'h0);
            chk("st_rsp",    32'(rsp_valid),  32'h0);
        end
        next_cycle();
        drive_req(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        hready = 1'b1;
        @(negedge clk);
        chk("st_rel_hwdata", hwdata,         32'hA5A50001);
        chk("st_rel_haddr",  haddr,          32'h204);
        chk("st_rel_rsp",    32'(rsp_valid), 32'h0);
        next_cycle();
        hrdata = 32'h12345678;
        @(negedge clk);
        chk("st_wr_rsp",    32'(rsp_valid), 32'h1);
        chk("st_wr_rdata",  rsp_rdata,      32'h0);
        chk("st_wr_err",    32'(rsp_err),   32'h0);
        chk("st_rd_htrans", 32'(htrans),    32'h0);
        next_cycle();
        hrdata = 32'h0;
        @(negedge clk);
        chk("st_rd_rsp",   32'(rsp_valid), 32'h1);
        chk("st_rd_rdata", rsp_rdata,      32'h12345678);
        next_cycle();
        @(negedge clk);
        chk("st_rsp_done", 32'(rsp_valid), 32'h0);

        // Two pipelined reads, first ends in ERROR
        next_cycle();
        drive_req(1'b1, 1'b0, 32'h300, 32'h0, 2'd2);
        @(negedge clk);
        chk("er_ready0", 32'(req_ready), 32'h1);
        next_cycle();
        drive_req(1'b1, 1'b0, 32'h304, 32'h0, 2'd2);
        @(negedge clk);
        chk("er_ready1", 32'(req_ready), 32'h1);
        next_cycle();
        drive_req(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        hresp  = 1'b1;
        hready = 1'b0;
        @(negedge clk);
        chk("er1_htrans", 32'(htrans),    32'h0);
        chk("er1_ready",  32'(req_ready), 32'h0);
        chk("er1_rsp",    32'(rsp_valid), 32'h0);
        next_cycle();
        hready = 1'b1;
        @(negedge clk);
        chk("er2_rsp",    32'(rsp_valid), 32'h0);
        chk("er2_ready",  32'(req_ready), 32'h0);
        chk("er2_htrans", 32'(htrans),    32'h0);
        next_cycle();
        hresp = 1'b0;
        @(negedge clk);
        chk("er_rsp1",       32'(rsp_valid), 32'h1);
        chk("er_rsp1_err",   32'(rsp_err),   32'h1);
        chk("er_rsp1_rdata", rsp_rdata,      32'h0);
        chk("er_idle_ready", 32'(req_ready), 32'h1);
        next_cycle();
        @(negedge clk);
        chk("er_rsp2",     32'(rsp_valid), 32'h1);
        chk("er_rsp2_err", 32'(rsp_err),   32'h1);
        next_cycle();
        @(negedge clk);
        chk("er_done_rsp",   32'(rsp_valid), 32'h0);
        chk("er_done_ready", 32'(req_ready), 32'h1);

        // Reset during a data-phase wait state
        next_cycle();
        drive_req(1'b1, 1'b1, 32'h400, 32'h55, 2'd2);
        @(negedge clk);
        chk("rs_ready", 32'(req_ready), 32'h1);
        next_cycle();
        drive_req(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        @(negedge clk);
        chk("rs_htrans", 32'(htrans), 32'h2);
        next_cycle();
        hready = 1'b0;
        @(negedge clk);
        chk("rs_hwdata_wait", hwdata, 32'h55);
        #2;
        rst = 1'b1;
        #1;
        chk("rs_async_htrans", 32'(htrans),    32'h0);
        chk("rs_async_haddr",  haddr,          32'h0);
        chk("rs_async_hwrite", 32'(hwrite),    32'h0);
        chk("rs_async_hwdata", hwdata,         32'h0);
        chk("rs_async_ready",  32'(req_ready), 32'h0);
        chk("rs_async_rsp",    32'(rsp_valid), 32'h0);
        next_cycle();
        rst    = 1'b0;
        hready = 1'b1;
        @(negedge clk);
        chk("rs_rel_ready", 32'(req_ready), 32'h1);
        chk("rs_rel_rsp",   32'(rsp_valid), 32'h0);
        next_cycle();
        @(negedge clk);
        chk("rs_rel_rsp2", 32'(rsp_valid), 32'h0);

        // Misaligned byte read, hready low while idle
        next_cycle();
        hready = 1'b0;
        drive_req(1'b1, 1'b0, 32'h3, 32'h0, 2'd0);
        @(negedge clk);
        chk("by_idle_ready", 32'(req_ready), 32'h1);
        next_cycle();
        hready = 1'b1;
        drive_req(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        @(negedge clk);
        chk("by_hsize",  32'(hsize),  32'h0);
        chk("by_haddr",  haddr,       32'h3);
        chk("by_htrans", 32'(htrans), 32'h2);
        next_cycle();
        hrdata = 32'hCAFE00AB;
        @(negedge clk);
        chk("by_dph_rsp", 32'(rsp_valid), 32'h0);
        next_cycle();
        hrdata = 32'h0;
        @(negedge clk);
        chk("by_rsp",   32'(rsp_valid), 32'h1);
        chk("by_rdata", rsp_rdata,      32'hCAFE00AB);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ahb_manager.md
AHB_MANAGER -- requirements
Module: ahb_manager

Interface
REQ-001 Parameters: none; all address and data widths SHALL be word_t (32 bits) from common_types_pkg.
REQ-002 clk  in  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req_valid  in  1  core request pending; req_ready  out  1  request accepted when both high.
REQ-005 req_write  in  1  1=write, 0=read; req_addr  in  32  byte address; req_wdata  in  32  write data; req_size  in  2  0=byte, 1=half, 2=word.
REQ-006 rsp_valid  out  1  one-cycle completion pulse; rsp_rdata  out  32  read data; rsp_err  out  1  transfer ended in ERROR.
REQ-007 AHB outputs: haddr 32, hwrite 1, hsize 3, htrans 2, hburst 3, hprot 4, hmastlock 1, hwdata 32.
REQ-008 AHB inputs: hready 1, hrdata 32, hresp 1 (0=OKAY, 1=ERROR).

Function
REQ-009 Only SINGLE transfers SHALL be issued: hburst=0, hprot=4'b0011, hmastlock=0, htrans in {IDLE=2'b00, NONSEQ=2'b10}.
REQ-010 Control FSM states: IDLE (no phase active), ADDR (address phase only), PIPE (address phase of transfer N+1 with data phase of N), DATA (data phase only), ERR2 (second error cycle).
REQ-011 On handshake at edge T, the next cycle SHALL drive htrans=NONSEQ with haddr/hwrite/hsize={1'b0,req_size} registered from the request; these values SHALL hold stable until an edge with hready=1.
REQ-012 Address phase completes at the first edge with hready=1; hwdata SHALL carry the captured wdata for the whole following data phase and SHALL stay stable while hready=0.
REQ-013 req_ready SHALL be 1 in IDLE; in ADDR/PIPE/DATA it SHALL be 1 only when hready=1 and hresp=0 (a new address phase may overlap the current data phase); it SHALL be 0 in ERR2 and when hresp=1.
REQ-014 Data phase completes on an edge with hready=1; rsp_valid SHALL pulse the following cycle with rsp_rdata=hrdata sampled at that edge for reads, rsp_rdata=0 for writes, rsp_err=0.
REQ-015 Back-to-back requests SHALL sustain one transfer per cycle with zero wait states; responses SHALL be returned in request order.
REQ-016 Error: on the first cycle with hresp=1, hready=0 in a data phase, htrans SHALL be driven IDLE that cycle; any pipelined address phase SHALL be cancelled and reported with rsp_err=1 and rsp_valid in order after the failing transfer; FSM enters ERR2.
REQ-017 In ERR2, on hready=1, rsp_valid=1 and rsp_err=1 SHALL pulse the next cycle; the FSM SHALL return to IDLE.
REQ-018 hready=0 in IDLE SHALL be ignored; htrans=IDLE SHALL be driven whenever no request is held.
REQ-019 req_addr misalignment to req_size SHALL not be checked; haddr SHALL be passed unmodified.

Reset
REQ-020 While rst=1: FSM=IDLE, htrans=IDLE, haddr=0, hwrite=0, hsize=0, hwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0.
REQ-021 Reset mid-transfer SHALL abandon the transfer without producing a response; the first cycle after deassertion SHALL have req_ready=1.

Structure
REQ-022 The htrans, hsize and hresp encodings and the FSM state enum SHALL be typedefs in common_types_pkg.
REQ-023 A single sub-module, ahb_phase_reg, SHALL hold the address-phase register set (addr/write/size/wdata plus valid) and SHALL be instantiated twice: once for the address phase and once for the data phase.

Verification
REQ-024 Single read, zero wait: req addr=0x100, hrdata=0xDEADBEEF -> NONSEQ in cycle T+1, rsp_valid in T+3, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-025 Four back-to-back word writes to 0x0,0x4,0x8,0xC with data 1..4, hready=1 -> four consecutive NONSEQ cycles, hwdata 1..4 one cycle later each, four consecutive rsp_valid pulses.
REQ-026 Write with hready=0 for 3 data cycles -> hwdata and pipelined haddr held stable for all 3 cycles, req_ready=0 during the stall, single rsp_valid after release.
REQ-027 Two pipelined reads, first returns ERROR -> htrans=IDLE in first error cycle, two responses both with rsp_err=1, FSM back in IDLE.
REQ-028 rst asserted during a data-phase wait state -> all outputs at reset values asynchronously, no rsp_valid pulse, req_ready=1 the cycle after release.
REQ-029 Byte read at 0x3 -> hsize=3'b000, haddr=0x3 unmodified.
